perm_sel_sequencer: RTL and testbench

//  Sequences the stage-select lines of the permutation data slices.
//  - Accepts permutation commands over a valid/ready handshake: a stage mask plus a beat count.
//  - Issues one data beat per cycle.
//  - Drives a per-stage select vector that is skewed one cycle per stage, so that each select

---
 rtl/perm_pkg.sv | 17 +
 rtl/perm_sel_skew.sv | 43 ++++
 rtl/perm_sel_sequencer.sv | 74 +++++++
 tb/tb_perm_sel_sequencer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/perm_pkg.sv
// Shared types and default sizes for the permutation select sequencer.
package perm_pkg;
   localparam int DEF_LOG2SLICES = 3;
   localparam int DEF_LEN_W      = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // One skew-pipe entry: a beat's select mask travels with the beat.
   typedef struct packed {
      logic                      valid;
      logic [DEF_LOG2SLICES-1:0] mask;
      logic                      last;
   } pipe_ent_t;
endpackage

// File: rtl/perm_sel_skew.sv
// Skew shift register for stage selects.
// Entry 0 is the live beat, and entries 1..STAGES-1 are registered.
module perm_sel_skew
   import perm_pkg::*;
#(
   parameter int STAGES = DEF_LOG2SLICES
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_en,
   input  pipe_ent_t         i_ent,
   output logic [STAGES-1:0] o_sel,
   output logic              o_done,
   output logic              o_any_vld
);
   pipe_ent_t [STAGES-1:0] w_pipe;

   assign w_pipe[0] = i_ent;

   genvar j;
   generate
      for (j = 1; j < STAGES; j++) begin : g_stg
         pipe_ent_t r_ent;
         always_ff @(posedge clk) begin
            if (reset)     r_ent <= '0;
            else if (i_en) r_ent <= w_pipe[j-1];
         end
         assign w_pipe[j] = r_ent;
      end
   endgenerate

   always_comb begin
      o_sel     = '0;
      o_any_vld = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
         o_sel[k]  = w_pipe[k].valid & w_pipe[k].mask[k];
         o_any_vld = o_any_vld | w_pipe[k].valid;
      end
   end

   // A held pipe keeps its last entry, so a blocked done fires once hold drops.
   assign o_done = i_en & w_pipe[STAGES-1].valid & w_pipe[STAGES-1].last;
endmodule

// File: rtl/perm_sel_sequencer.sv
// Command FSM and beat counter feeding the skewed stage-select pipe.
// LOG2SLICES must match the package's pipe-entry mask width.
module perm_sel_sequencer
   import perm_pkg::*;
#(
   parameter int LOG2SLICES = DEF_LOG2SLICES,
   parameter int LEN_W      = DEF_LEN_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [LOG2SLICES-1:0] cmd_mask,
   input  logic [LEN_W-1:0]      cmd_len,
   input  logic                  hold,
   output logic                  beat_o,
   output logic [LOG2SLICES-1:0] sel_o,
   output logic                  busy_o,
   output logic                  done_o
);
   state_t                r_state;
   logic [LEN_W-1:0]      r_rem;
   logic [LOG2SLICES-1:0] r_mask;
   logic                  r_zdone;
   logic                  w_run;
   logic                  w_last;
   logic                  w_acc;
   logic                  w_skew_done;
   logic                  w_any_vld;
   pipe_ent_t             w_ent;

   assign w_run     = (r_state == ST_RUN);
   assign w_last    = (r_rem == LEN_W'(1));
   assign cmd_ready = !hold & (!w_run | w_last);
   assign w_acc     = cmd_valid & cmd_ready;
   assign beat_o    = w_run & !hold;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_rem   <= '0;
         r_mask  <= '0;
         r_zdone <= 1'b0;
      end else if (!hold) begin
         r_zdone <= w_acc & (cmd_len == '0);
         if (w_acc) begin
            r_mask  <= cmd_mask;
            r_rem   <= cmd_len;
            r_state <= (cmd_len == '0) ? ST_IDLE : ST_RUN;
         end else if (w_run) begin
            r_rem <= r_rem - LEN_W'(1);
            if (w_last) r_state <= ST_IDLE;
         end
      end
   end

   // Entry 0 stays valid through a hold so sel_o[0] holds its value too.
   assign w_ent.valid = w_run;
   assign w_ent.mask  = r_mask;
   assign w_ent.last  = w_last;

   perm_sel_skew #(.STAGES(LOG2SLICES)) u_skew (
      .clk       (clk),
      .reset     (reset),
      .i_en      (!hold),
      .i_ent     (w_ent),
      .o_sel     (sel_o),
      .o_done    (w_skew_done),
      .o_any_vld (w_any_vld)
   );

   assign busy_o = w_run | w_any_vld;
   assign done_o = w_skew_done | (r_zdone & !hold);
endmodule

// File: tb/tb_perm_sel_sequencer.sv
// Directed bench for perm_sel_sequencer with hand-derived per-cycle expectations.
module tb_perm_sel_sequencer;
   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_mask;
   logic [7:0] cmd_len;
   logic       hold;
   logic       beat_o;
   logic [2:0] sel_o;
   logic       busy_o;
   logic       done_o;

   int n_tests = 0;
   int n_fail  = 0;

   perm_sel_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_mask  (cmd_mask),
      .cmd_len   (cmd_len),
      .hold      (hold),
      .beat_o    (beat_o),
      .sel_o     (sel_o),
      .busy_o    (busy_o),
      .done_o    (done_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [2:0] m, input logic [7:0] l, input logic h);
      cmd_valid = v;
      cmd_mask  = m;
      cmd_len   = l;
      hold      = h;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] vec(input logic b, input logic [2:0] s, input logic d,
                                       input logic bz);
      return {26'd0, b, s, d, bz};
   endfunction

   function automatic logic [31:0] obs();
      return vec(beat_o, sel_o, done_o, busy_o);
   endfunction

   initial begin
      int nbeat;
      int ndone;
      int done_c;

      reset = 1'b1;
      drive(1'b0, 3'b000, 8'd0, 1'b0);
      step();
      step();
      chk("reset outs", obs(), vec(1'b0, 3'b000, 1'b0, 1'b0));
      chk("reset ready", 32'(cmd_ready), 32'd1);
      reset = 1'b0;

      // T1: mask 101 len 4
      for (int c = 0; c <= 7; c++) begin
         drive(c == 0, 3'b101, 8'd4, 1'b0);
         if (c == 0) chk("t1 ready", 32'(cmd_ready), 32'd1);
         chk($sformatf("t1 c%0d", c), obs(),
             vec(c >= 1 && c <= 4, {c >= 3 && c <= 6, 1'b0, c >= 1 && c <= 4},
                 c == 6, c >= 1 && c <= 6));
         step();
      end

      // T2: back-to-back, second command offered early while not ready
      for (int c = 0; c <= 8; c++) begin
         if (c == 0)                drive(1'b1, 3'b001, 8'd2, 1'b0);
         else if (c == 1 || c == 2) drive(1'b1, 3'b110, 8'd3, 1'b0);
         else                       drive(1'b0, 3'b000, 8'd0, 1'b0);
         if (c == 1) chk("t2 ready c1", 32'(cmd_ready), 32'd0);
         if (c == 2) chk("t2 ready c2", 32'(cmd_ready), 32'd1);
         chk($sformatf("t2 c%0d", c), obs(),
             vec(c >= 1 && c <= 5, {c >= 5 && c <= 7, c >= 4 && c <= 6, c == 1 || c == 2},
                 c == 4 || c == 7, c >= 1 && c <= 7));
         step();
      end

      // T3: zero-length command
      for (int c = 0; c <= 3; c++) begin
         drive(c == 0, 3'b111, 8'd0, 1'b0);
         if (c == 0) chk("t3 ready", 32'(cmd_ready), 32'd1);
         chk($sformatf("t3 c%0d", c), obs(), vec(1'b0, 3'b000, c == 1, 1'b0));
         step();
      end

      // T4: hold for 2 cycles at beat 3
      nbeat = 0;
      for (int c = 0; c <= 10; c++) begin
         drive(c == 0, 3'b111, 8'd5, c == 3 || c == 4);
         if (c == 3) chk("t4 ready hold", 32'(cmd_ready), 32'd0);
         if (beat_o) nbeat++;
         chk($sformatf("t4 c%0d", c), obs(),
             vec(c == 1 || c == 2 || (c >= 5 && c <= 7),
                 {c >= 3 && c <= 9, c >= 2 && c <= 8, c >= 1 && c <= 7},
                 c == 9, c >= 1 && c <= 9));
         step();
      end
      chk("t4 beats", 32'(nbeat), 32'd5);

      // Hold while idle blocks acceptance
      drive(1'b1, 3'b111, 8'd1, 1'b1);
      chk("idle hold ready", 32'(cmd_ready), 32'd0);
      step();
      drive(1'b0, 3'b000, 8'd0, 1'b0);
      chk("idle hold busy", 32'(busy_o), 32'd0);
      step();

      // T5: reset during beat 4 of an 8-beat command
      for (int c = 0; c <= 4; c++) begin
         if (c == 4) reset = 1'b1;
         drive(c == 0, 3'b111, 8'd8, 1'b0);
         chk($sformatf("t5 beat c%0d", c), 32'(beat_o), 32'(c >= 1));
         step();
      end
      reset = 1'b0;
      drive(1'b0, 3'b000, 8'd0, 1'b0);
      chk("t5 post sel", 32'(sel_o), 32'd0);
      chk("t5 post busy", 32'(busy_o), 32'd0);
      chk("t5 post ready", 32'(cmd_ready), 32'd1);
      ndone = 0;
      for (int c = 0; c < 20; c++) begin
         drive(1'b0, 3'b000, 8'd0, 1'b0);
         if (done_o) ndone++;
         step();
      end
      chk("t5 no done", 32'(ndone), 32'd0);

      // T6: maximum length
      nbeat  = 0;
      ndone  = 0;
      done_c = -1;
      for (int c = 0; c <= 300; c++) begin
         drive(c == 0, 3'b010, 8'd255, 1'b0);
         if (c == 2) chk("t6 sel c2", 32'(sel_o), 32'd2);
         if (beat_o) nbeat++;
         if (done_o) begin
            ndone++;
            done_c = c;
         end
         step();
      end
      chk("t6 beats", 32'(nbeat), 32'd255);
      chk("t6 dones", 32'(ndone), 32'd1);
      chk("t6 done cycle", 32'(done_c), 32'd257);
      chk("t6 busy end", 32'(busy_o), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
